// File: rtl/pipeline_pkg.sv
// Shared encodings for the fetch-side pipeline control: branch kinds, NOP word
// and the IF-stage debug FSM states.
package pipeline_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } branch_e;

  typedef enum logic [1:0] {
    IF_RUN    = 2'd0,
    IF_STALL  = 2'd1,
    IF_BUBBLE = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}}))
      count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/if_stage_ctrl.sv
// Fetch-stage control: PC register, IF/ID register, redirect/bubble handling and
// stall/flush event counters driven by the hazard unit's enables.
module if_stage_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             IF_ID_write,
  input  logic             flush,
  input  logic [1:0]       branch,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      inst_in,
  output logic [31:0]      pc,
  output logic [31:0]      IF_ID_inst,
  output logic [31:0]      IF_ID_pc4,
  output logic             IF_ID_valid,
  output logic [1:0]       if_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  if_state_e   state_q, state_d;

  logic        stall;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  always_comb begin
    stall       = !pc_write || !IF_ID_write;
    // A flush with no branch kind is a protocol error and falls through to sequential.
    redirect    = !stall && flush && (branch != BR_NONE);
    pc_plus4    = pc_q + PC_STEP;
    redirect_pc = (branch == BR_JMP) ? jump_target : branch_target;
  end

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    state_d = IF_RUN;

    if (stall) begin
      // Each register honours only its own enable; the other keeps advancing.
      if (pc_write) pc_d = pc_plus4;
      if (IF_ID_write) begin
        inst_d  = inst_in;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
      state_d = IF_STALL;
    end else if (redirect) begin
      pc_d    = redirect_pc;
      inst_d  = NOP_INST;
      pc4_d   = '0;
      valid_d = 1'b0;
      state_d = IF_BUBBLE;
    end else begin
      pc_d    = pc_plus4;
      inst_d  = inst_in;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      state_d = IF_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      state_q <= IF_RUN;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect),
    .count (flush_cnt)
  );

  assign pc          = pc_q;
  assign IF_ID_inst  = inst_q;
  assign IF_ID_pc4   = pc4_q;
  assign IF_ID_valid = valid_q;
  assign if_state    = state_q;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Bench for if_stage_ctrl: directed scenarios with literal expectations, then
// randomized control traffic compared every cycle against a behavioural model.
module tb_if_stage_ctrl;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic             clk;
  logic             rst;
  logic             pc_write;
  logic             IF_ID_write;
  logic             flush;
  logic [1:0]       branch;
  logic [31:0]      branch_target;
  logic [31:0]      jump_target;
  logic [31:0]      inst_in;
  logic [31:0]      pc;
  logic [31:0]      IF_ID_inst;
  logic [31:0]      IF_ID_pc4;
  logic             IF_ID_valid;
  logic [1:0]       if_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  if_stage_ctrl #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .IF_ID_write   (IF_ID_write),
    .flush         (flush),
    .branch        (branch),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .inst_in       (inst_in),
    .pc            (pc),
    .IF_ID_inst    (IF_ID_inst),
    .IF_ID_pc4     (IF_ID_pc4),
    .IF_ID_valid   (IF_ID_valid),
    .if_state      (if_state),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: the word at address a is 0x1111_0000 + a.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h1111_0000 + a;
  endfunction

  always_comb inst_in = imem(pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: what each register must hold after each edge.
  logic [31:0]      m_pc, m_inst, m_pc4;
  logic             m_valid;
  logic [1:0]       m_state;
  logic [CNT_W-1:0] m_stall, m_flush;
  logic             m_ok = 1'b0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ok <= 1'b1;
      m_pc <= 32'h0; m_inst <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
      m_state <= 2'd0; m_stall <= '0; m_flush <= '0;
    end else if (!pc_write || !IF_ID_write) begin
      m_pc <= pc_write ? m_pc + 32'd4 : m_pc;
      if (IF_ID_write) begin
        m_inst <= imem(m_pc); m_pc4 <= m_pc + 32'd4; m_valid <= 1'b1;
      end
      m_state <= 2'd1;
      m_stall <= sat_inc(m_stall);
    end else if (flush && branch != 2'b00) begin
      m_pc <= (branch == 2'b11) ? jump_target : branch_target;
      m_inst <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
      m_state <= 2'd2;
      m_flush <= sat_inc(m_flush);
    end else begin
      m_pc <= m_pc + 32'd4;
      m_inst <= imem(m_pc); m_pc4 <= m_pc + 32'd4; m_valid <= 1'b1;
      m_state <= 2'd0;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_pc", pc, m_pc);
      chk("model_inst", IF_ID_inst, m_inst);
      chk("model_pc4", IF_ID_pc4, m_pc4);
      chk("model_valid", 32'(IF_ID_valid), 32'(m_valid));
      chk("model_state", 32'(if_state), 32'(m_state));
      chk("model_stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("model_flush_cnt", 32'(flush_cnt), 32'(m_flush));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc_write = 1'b1; IF_ID_write = 1'b1; flush = 1'b0;
    branch = 2'b00; branch_target = 32'h0; jump_target = 32'h0;

    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", IF_ID_inst, 32'h0);
    chk("rst_valid", 32'(IF_ID_valid), 32'd0);
    chk("rst_state", 32'(if_state), 32'd0);
    chk("rst_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);
    rst = 1'b0;

    step();
    chk("seq_pc4", pc, 32'h4);
    chk("seq_inst0", IF_ID_inst, 32'h1111_0000);
    chk("seq_pc4_0", IF_ID_pc4, 32'h4);
    chk("seq_valid", 32'(IF_ID_valid), 32'd1);
    step();
    chk("seq_pc8", pc, 32'h8);

    pc_write = 1'b0; IF_ID_write = 1'b0;
    step();
    chk("stall1_pc", pc, 32'h8);
    chk("stall1_state", 32'(if_state), 32'd1);
    step();
    chk("stall2_pc", pc, 32'h8);
    chk("stall2_inst", IF_ID_inst, 32'h1111_0004);
    chk("stall2_pc4", IF_ID_pc4, 32'h8);
    chk("stall2_cnt", 32'(stall_cnt), 32'd2);
    pc_write = 1'b1; IF_ID_write = 1'b1;
    step();
    chk("resume_pc", pc, 32'hC);
    chk("resume_inst", IF_ID_inst, 32'h1111_0008);
    chk("resume_state", 32'(if_state), 32'd0);
    step();
    chk("pc16", pc, 32'h10);

    flush = 1'b1; branch = 2'b01; branch_target = 32'h40;
    step();
    chk("br_pc", pc, 32'h40);
    chk("br_inst", IF_ID_inst, 32'h0);
    chk("br_valid", 32'(IF_ID_valid), 32'd0);
    chk("br_state", 32'(if_state), 32'd2);
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    flush = 1'b0; branch = 2'b00;
    step();
    chk("br_next_inst", IF_ID_inst, 32'h1111_0040);
    chk("br_next_pc4", IF_ID_pc4, 32'h44);
    chk("br_next_pc", pc, 32'h44);

    flush = 1'b1; branch = 2'b11; jump_target = 32'h100; pc_write = 1'b0;
    step();
    chk("stallflush_pc", pc, 32'h44);
    chk("stallflush_fcnt", 32'(flush_cnt), 32'd1);
    chk("stallflush_scnt", 32'(stall_cnt), 32'd3);
    pc_write = 1'b1;
    step();
    chk("jmp_pc", pc, 32'h100);
    chk("jmp_fcnt", 32'(flush_cnt), 32'd2);

    jump_target = 32'hFFFF_FFF8;
    step();
    chk("wrap_pc0", pc, 32'hFFFF_FFF8);
    flush = 1'b0; branch = 2'b00;
    step();
    chk("wrap_pc1", pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc2", pc, 32'h0);
    chk("wrap_inst", IF_ID_inst, 32'h1110_FFFC);
    chk("wrap_pc4", IF_ID_pc4, 32'h0);

    pc_write = 1'b0; IF_ID_write = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("midstall_rst_pc", pc, 32'h0);
    chk("midstall_rst_inst", IF_ID_inst, 32'h0);
    chk("midstall_rst_valid", 32'(IF_ID_valid), 32'd0);
    chk("midstall_rst_state", 32'(if_state), 32'd0);
    chk("midstall_rst_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < (1 << CNT_W) + 3; i++) step();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    chk("sat_pc", pc, 32'h0);
    pc_write = 1'b1; IF_ID_write = 1'b1;
    step();
    chk("sat_hold_cnt", 32'(stall_cnt), 32'd15);
    chk("sat_release_pc", pc, 32'h4);

    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      pc_write      = ($urandom_range(0, 4) != 0);
      IF_ID_write   = ($urandom_range(0, 4) != 0);
      flush         = ($urandom_range(0, 2) == 0);
      branch        = 2'($urandom_range(0, 3));
      branch_target = $urandom & 32'hFFFF_FFFC;
      jump_target   = $urandom & 32'hFFFF_FFFC;
      step();
    end

    rst = 1'b0; pc_write = 1'b1; IF_ID_write = 1'b1; flush = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage_ctrl.md
# if_stage_ctrl

Fetch-side responder to the data hazard detection unit: owns the PC register and the IF/ID pipeline register and applies the unit's stall (`pc_write`, `IF_ID_write`) and `flush` outputs to them. It sits between instruction memory and the ID stage. It also redirects the PC on taken branches and jumps, inserts NOP bubbles, and keeps saturating stall and flush event counters for the testbench and debug.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000, PC value loaded on reset.
- `CNT_W`, default 16, width of each event counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `pc_write`  in  1  0 = hold PC (load-use stall).
- `IF_ID_write`  in  1  0 = hold IF/ID register.
- `flush`  in  1  redirect request from the hazard unit.
- `branch`  in  2  00 none, 01 beq, 10 bne, 11 jump.
- `branch_target`  in  32  ID-stage computed branch target.
- `jump_target`  in  32  ID-stage computed jump target.
- `inst_in`  in  32  instruction memory read data for the current `pc` (combinational).
- `pc`  out  32  current fetch address.
- `IF_ID_inst`  out  32  instruction presented to ID.
- `IF_ID_pc4`  out  32  fetch address + 4 of `IF_ID_inst`.
- `IF_ID_valid`  out  1  0 = IF/ID holds a bubble.
- `if_state`  out  2  FSM state: 0 RUN, 1 STALL, 2 BUBBLE.
- `stall_cnt`  out  CNT_W  cycles spent stalled.
- `flush_cnt`  out  CNT_W  redirects taken.

## Operation

- Action priority each cycle: reset > stall > redirect > sequential.
- Reset (`rst`=1 at edge):
  - `pc`=RESET_PC.
  - `IF_ID_inst`=0, `IF_ID_pc4`=0, `IF_ID_valid`=0.
  - `if_state`=RUN.
  - `stall_cnt`=0, `flush_cnt`=0.
  - Reset mid-stall or mid-bubble discards all state.
- Stall (`pc_write`=0 or `IF_ID_write`=0):
  - Each register holds independently when its own enable is 0.
  - `flush` is ignored this cycle. The branch in ID re-evaluates after the stall.
  - `stall_cnt` increments, saturating at all-ones.
  - State goes to STALL.
- Redirect (`flush`=1, `branch`≠00, no stall):
  - `pc` loads `jump_target` when `branch`=11, else `branch_target`.
  - IF/ID loads a bubble: `IF_ID_inst`=32'h0 (NOP), `IF_ID_pc4`=0, `IF_ID_valid`=0.
  - `flush_cnt` increments, saturating.
  - State goes to BUBBLE.
- `flush`=1 with `branch`=00 is a protocol error. Treat it as sequential; neither counter changes.
- Sequential (no stall, no redirect):
  - `pc` ← `pc`+4, modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is legal.
  - `IF_ID_inst` ← `inst_in`, `IF_ID_pc4` ← `pc`+4, `IF_ID_valid` ← 1.
  - State goes to RUN.
- FSM transitions are decided purely by the current-cycle action above. Any state can move to any state. The FSM carries no behaviour beyond reporting; it is a debug and coverage output.

## Timing

- All outputs are registered and change only at the rising edge of `clk`.
- Control inputs are sampled at the same edge in which they take effect.
- Redirect latency: `pc` shows the target one cycle after the `flush` edge. The next instruction reaches IF/ID one cycle after that. Exactly one bubble is inserted per redirect.
- Stall latency is zero: the hold applies at the same edge. N stalled cycles re-present the same `pc` for N+1 cycles in total.
- Back-to-back redirects are each honoured. Each one inserts its own bubble and adds 1 to `flush_cnt`.
- Stall and flush in the same cycle: the stall wins, and `flush_cnt` does not change.

## Structure

- Shared package `pipeline_pkg`:
  - branch encodings `BR_NONE`, `BR_BEQ`, `BR_BNE`, `BR_JMP`;
  - `NOP_INST`=32'h0;
  - FSM state encodings `IF_RUN`, `IF_STALL`, `IF_BUBBLE`.
- One sub-module, `sat_counter`, parameterised by width, with inputs `clk`, `rst`, `inc` and output `count`. It is instantiated twice, once per event counter.
- Everything else (PC register, next-PC mux, IF/ID register, FSM) is inline.

## Test plan

- Reset, then 4 clean cycles with `inst_in` = 32'h1111_0000 + `pc`:
  - `pc` goes 0, 4, 8, 12, 16;
  - IF/ID carries each instruction one cycle later with `IF_ID_pc4` = `pc`+4 and `valid`=1;
  - both counters stay 0.
- At `pc`=8, hold `pc_write`=`IF_ID_write`=0 for 2 cycles:
  - `pc` stays 8 and IF/ID is unchanged for both cycles;
  - `if_state`=STALL, `stall_cnt`=2;
  - fetch then resumes at 12.
- `flush`=1, `branch`=01, `branch_target`=32'h40 at `pc`=16:
  - next cycle `pc`=32'h40, `IF_ID_inst`=0, `valid`=0, `if_state`=BUBBLE, `flush_cnt`=1;
  - the cycle after, IF/ID holds the instruction fetched from 32'h40.
- `flush`=1, `branch`=11, `jump_target`=32'h100, with `pc_write`=0 in the same cycle:
  - `pc` holds and `flush_cnt` is unchanged;
  - next cycle, with the stall released, `pc` goes to 32'h100.
- Force `pc` near 32'hFFFF_FFF8 via `jump_target`, then run sequentially:
  - `pc` goes FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - Assert `rst` mid-stall: all outputs reach reset values at that edge.
- Hold a stall for 2^CNT_W+3 cycles with `CNT_W`=4: `stall_cnt` saturates at 15 and does not wrap.
